// File: rtl/ram32x3_arbiter.sv
// ram32x3_arbiter: round-robin two-requester front end for a 32x3 single-port RAM; define INIT_CLEAR_EN to add the power-up clear
module ram32x3_arbiter #(
  parameter logic [2:0] CLEAR_VALUE = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [4:0] addr_a,
  input  logic [4:0] addr_b,
  input  logic [2:0] wdata_a,
  input  logic [2:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       rvalid_a,
  output logic       rvalid_b,
  output logic [2:0] rdata_a,
  output logic [2:0] rdata_b,
  output logic       busy,
  output logic [4:0] ram_address,
  output logic [2:0] ram_data,
  output logic       ram_wren,
  input  logic [2:0] ram_q
);
  logic clearing, hold, last_b, rv_a, rv_b, en;
  logic [4:0] clr_addr;
`ifdef INIT_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_next;
  logic [4:0] cnt;
  // state register and clear counter; the counter only advances while clearing
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      cnt <= 5'd0;
    end else begin
      state <= state_next;
      if (state == CLEAR) cnt <= cnt + 5'd1;
    end
  end
  // leave CLEAR after the cycle that writes address 31
  always_comb state_next = (state == CLEAR && cnt == 5'd31) ? RUN : state;
  assign clearing = state == CLEAR;
  assign clr_addr = cnt;
`else
  assign clearing = 1'b0;
  assign clr_addr = 5'd0;
`endif
  // arbitration history, one-cycle post-reset grant blackout and read-valid pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      hold <= 1'b1;
      last_b <= 1'b1;
      rv_a <= 1'b0;
      rv_b <= 1'b0;
    end else begin
      hold <= 1'b0;
      if (gnt_a | gnt_b) last_b <= gnt_b;
      rv_a <= gnt_a & ~we_a;
      rv_b <= gnt_b & ~we_b;
    end
  end
  // grants, RAM drive and read returns; reset masks every output immediately
  always_comb begin
    en = ~reset & ~hold & ~clearing;
    gnt_a = en & req_a & (~req_b | last_b);
    gnt_b = en & req_b & ~gnt_a;
    ram_wren = ~reset & (clearing | (gnt_a & we_a) | (gnt_b & we_b));
    ram_address = clearing ? clr_addr : gnt_b ? addr_b : addr_a;
    ram_data = clearing ? CLEAR_VALUE : gnt_b ? wdata_b : wdata_a;
    busy = clearing;
    rvalid_a = rv_a & ~reset;
    rvalid_b = rv_b & ~reset;
    rdata_a = rvalid_a ? ram_q : 3'b000;
    rdata_b = rvalid_b ? ram_q : 3'b000;
  end
endmodule
